dec_4_92_batch32: RTL and testbench

- Decoder layer of the arrhythmia autoencoder; the inverse of the 92→4 encoder layer.
- Expands a 4-element latent vector back to 92 reconstructed samples: y[j] = b[j] + Σk z[k]·w[j*4+k].
- Start/done handshake. Computes BATCH outputs per batch pass, reusing BATCH×LATENT multipliers across passes.
- Feeds the reconstruction-error stage that follows it.

---
 rtl/dec_4_92_batch32.sv | 140 ++++++++++++++
 tb/tb_dec_4_92_batch32.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/dec_4_92_batch32.sv
// Decoder layer: expands a 4-element Q8.8 latent vector to 92 outputs, BATCH lanes per pass.
// Define DEC_RELU_EN to clamp negative output words to zero.
module dec_4_92_batch32 #(
    parameter int unsigned BITSIZE     = 16,
    parameter int unsigned LATENT_SIZE = 4,
    parameter int unsigned OUT_SIZE    = 92,
    parameter int unsigned BATCH       = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  start,
    input  logic [BITSIZE*LATENT_SIZE-1:0]        z,
    input  logic [BITSIZE*OUT_SIZE*LATENT_SIZE-1:0] w,
    input  logic [BITSIZE*OUT_SIZE-1:0]           b,
    output logic [BITSIZE*OUT_SIZE-1:0]           y,
    output logic                                  busy,
    output logic                                  done
);

    localparam int unsigned FRAC        = 8;
    localparam int unsigned BATCH_COUNT = (OUT_SIZE + BATCH - 1) / BATCH;
    localparam int unsigned IDX_W       = (BATCH_COUNT > 1) ? $clog2(BATCH_COUNT) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BATCH_COUNT - 1);

    typedef logic [BITSIZE-1:0] word_t;
    typedef enum logic [2:0] {StIdle, StLoad, StMul, StAcc, StDone} state_e;

    state_e           state;
    logic [IDX_W-1:0] batch_idx;
    word_t            z_in      [LATENT_SIZE];
    word_t            z_reg     [LATENT_SIZE];
    word_t            w_arr     [BATCH_COUNT][BATCH][LATENT_SIZE];
    word_t            b_arr     [BATCH_COUNT][BATCH];
    logic             lane_valid[BATCH_COUNT][BATCH];
    word_t            y_arr     [BATCH_COUNT][BATCH];
    word_t            mul_reg   [BATCH][LATENT_SIZE];
    word_t            prod      [BATCH][LATENT_SIZE];
    word_t            acc_sum   [BATCH];

    // Signed Q8.8 multiply: full 32-bit product, keep bits [23:8].
    function automatic word_t fxp_mul(input word_t a, input word_t m);
        logic signed [2*BITSIZE-1:0] p;
        p = (2*BITSIZE)'($signed(a)) * (2*BITSIZE)'($signed(m));
        return p[FRAC +: BITSIZE];
    endfunction

    for (genvar k = 0; k < LATENT_SIZE; k++) begin : g_z
        assign z_in[k] = z[k*BITSIZE +: BITSIZE];
    end

    // Lanes past OUT_SIZE in the last pass see zero weights/bias and are never written.
    for (genvar c = 0; c < BATCH_COUNT; c++) begin : g_batch
        for (genvar l = 0; l < BATCH; l++) begin : g_lane
            localparam int unsigned J = c * BATCH + l;
            if (J < OUT_SIZE) begin : g_valid
                assign lane_valid[c][l] = 1'b1;
                assign b_arr[c][l]      = b[J*BITSIZE +: BITSIZE];
                for (genvar k = 0; k < LATENT_SIZE; k++) begin : g_w
                    assign w_arr[c][l][k] = w[(J*LATENT_SIZE+k)*BITSIZE +: BITSIZE];
                end
            end else begin : g_pad
                assign lane_valid[c][l] = 1'b0;
                assign b_arr[c][l]      = '0;
                for (genvar k = 0; k < LATENT_SIZE; k++) begin : g_w
                    assign w_arr[c][l][k] = '0;
                end
            end
        end
    end

    for (genvar j = 0; j < OUT_SIZE; j++) begin : g_y
        assign y[j*BITSIZE +: BITSIZE] = y_arr[j/BATCH][j%BATCH];
    end

    always_comb begin
        for (int l = 0; l < BATCH; l++) begin
            acc_sum[l] = b_arr[batch_idx][l];
            for (int k = 0; k < LATENT_SIZE; k++) begin
                prod[l][k] = fxp_mul(z_reg[k], w_arr[batch_idx][l][k]);
                acc_sum[l] = acc_sum[l] + mul_reg[l][k];
            end
`ifdef DEC_RELU_EN
            if (acc_sum[l][BITSIZE-1]) acc_sum[l] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= StIdle;
            batch_idx <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            for (int k = 0; k < LATENT_SIZE; k++) z_reg[k] <= '0;
            for (int l = 0; l < BATCH; l++) begin
                for (int k = 0; k < LATENT_SIZE; k++) mul_reg[l][k] <= '0;
            end
            for (int c = 0; c < BATCH_COUNT; c++) begin
                for (int l = 0; l < BATCH; l++) y_arr[c][l] <= '0;
            end
        end else begin
            unique case (state)
                StIdle: begin
                    if (start) begin
                        state <= StLoad;
                        busy  <= 1'b1;
                    end
                end
                StLoad: begin
                    z_reg     <= z_in;
                    batch_idx <= '0;
                    state     <= StMul;
                end
                StMul: begin
                    mul_reg <= prod;
                    state   <= StAcc;
                end
                StAcc: begin
                    for (int l = 0; l < BATCH; l++) begin
                        if (lane_valid[batch_idx][l]) y_arr[batch_idx][l] <= acc_sum[l];
                    end
                    if (batch_idx == LAST_IDX) begin
                        state <= StDone;
                        done  <= 1'b1;
                    end else begin
                        batch_idx <= batch_idx + 1'b1;
                        state     <= StMul;
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dec_4_92_batch32.sv
// Directed, table-driven bench for dec_4_92_batch32 plus hand-written multi-cycle sequences.
module tb_dec_4_92_batch32;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [63:0]   z;
    logic [5887:0] w;
    logic [1471:0] b;
    logic [1471:0] y;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        logic [63:0] z;
        logic [15:0] w0;        // w(j,0), or w(91,k) for all k when last_only
        logic [15:0] wr;        // w(j,k) for k>0
        bit          last_only;
        bit          bshift;    // b(j) = j<<8 when set, else 0
        logic [15:0] base;      // hand-computed sum excluding bias
    } vec_t;

    vec_t vecs[6];

    dec_4_92_batch32 dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .z     (z),
        .w     (w),
        .b     (b),
        .y     (y),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ywd(input int j);
        return y[j*16 +: 16];
    endfunction

    function automatic logic [15:0] exp_y(input vec_t v, input int j);
        logic [15:0] e;
        if (v.last_only) e = (j == 91) ? v.base : 16'h0000;
        else             e = v.base + (v.bshift ? 16'(j << 8) : 16'h0000);
`ifdef DEC_RELU_EN
        if (e[15]) e = 16'h0000;
`endif
        return e;
    endfunction

    task automatic check_y(input string name, input vec_t v);
        int bad = -1;
        int idx;
        for (int j = 0; j < 92; j++) begin
            if (bad < 0 && ywd(j) !== exp_y(v, j)) bad = j;
        end
        idx = (bad < 0) ? 91 : bad;
        check($sformatf("%s_y[%0d]", name, idx), {16'h0, ywd(idx)}, {16'h0, exp_y(v, idx)});
    endtask

    task automatic set_cfg(input vec_t v);
        z = v.z;
        for (int j = 0; j < 92; j++) begin
            b[j*16 +: 16] = v.bshift ? 16'(j << 8) : 16'h0000;
            for (int k = 0; k < 4; k++) begin
                if (v.last_only) w[(j*4+k)*16 +: 16] = (j == 91) ? v.w0 : 16'h0000;
                else             w[(j*4+k)*16 +: 16] = (k == 0) ? v.w0 : v.wr;
            end
        end
    endtask

    // Called #1 after a rising edge with the DUT idle; returns at the sample where done is seen.
    task automatic run_txn(output int lat, output bit busy_bad);
        lat      = -1;
        busy_bad = 1'b0;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (!busy) busy_bad = 1'b1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (!busy) busy_bad = 1'b1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    initial begin
        int          lat;
        bit          bb;
        int          dcount;
        int          dn;
        bit          busy_late;
        logic [15:0] y91_hist[8];
        logic [15:0] y32_hist[8];
        logic [15:0] y0_hist[8];

        vecs[0] = '{"ident",    {16'h0000, 16'h0000, 16'h0000, 16'h0100}, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'h0100};
        vecs[1] = '{"biassum",  {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, 16'h0100, 16'h0100, 1'b0, 1'b1, 16'h0280};
        vecs[2] = '{"negative", {16'h0000, 16'h0000, 16'h0000, 16'hFF00}, 16'h0100, 16'h0000, 1'b0, 1'b0, 16'hFF00};
        vecs[3] = '{"lastlane", {16'h0100, 16'h0100, 16'h0100, 16'h0100}, 16'h0100, 16'h0000, 1'b1, 1'b0, 16'h0400};
        vecs[4] = '{"frac",     {16'h0000, 16'h0001, 16'hFFFF, 16'h0180}, 16'hFF80, 16'h0080, 1'b0, 1'b0, 16'hFF3F};
        vecs[5] = '{"wrap",     {16'h0000, 16'h0000, 16'h7F00, 16'h7F00}, 16'h0100, 16'h0100, 1'b0, 1'b1, 16'hFE00};

        reset = 1'b0;
        start = 1'b0;
        z     = '0;
        w     = '0;
        b     = '0;
        #12;
        check("reset_y_nonzero", {31'b0, |y}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            set_cfg(vecs[i]);
            run_txn(lat, bb);
            check({vecs[i].name, "_latency"}, 32'(lat), 32'd7);
            check({vecs[i].name, "_busy_drop"}, 32'(bb), 32'd0);
            check_y(vecs[i].name, vecs[i]);
            @(posedge clk); #1;
            check({vecs[i].name, "_idle_done_busy"}, {30'b0, done, busy}, 32'd0);
        end

        // Last-pass boundary: slices 64..91 must change only on the third ACC edge.
        set_cfg(vecs[1]);
        run_txn(lat, bb);
        @(posedge clk); #1;
        set_cfg(vecs[3]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 7; n++) begin
            @(posedge clk); #1;
            y91_hist[n] = ywd(91);
            y32_hist[n] = ywd(32);
            y0_hist[n]  = ywd(0);
        end
        check("bnd_y0_after_acc1", {16'h0, y0_hist[3]}, {16'h0, exp_y(vecs[3], 0)});
        check("bnd_y32_hold_acc1", {16'h0, y32_hist[3]}, {16'h0, exp_y(vecs[1], 32)});
        check("bnd_y32_after_acc2", {16'h0, y32_hist[5]}, {16'h0, exp_y(vecs[3], 32)});
        check("bnd_y91_hold", {16'h0, y91_hist[6]}, {16'h0, exp_y(vecs[1], 91)});
        check("bnd_y91_after_acc3", {16'h0, y91_hist[7]}, {16'h0, exp_y(vecs[3], 91)});
        check_y("bnd_final", vecs[3]);
        @(posedge clk); #1;

        // Start while busy and start during DONE are both ignored; z changes after LOAD.
        set_cfg(vecs[0]);
        dcount    = 0;
        dn        = -1;
        busy_late = 1'b0;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 16; n++) begin
            @(posedge clk); #1;
            if (dn >= 0 && n > dn && busy) busy_late = 1'b1;
            if (dn >= 0 && n == dn + 1) start = 1'b0;
            if (done) begin
                dcount++;
                if (dn < 0) begin
                    dn    = n;
                    start = 1'b1;
                end
            end
            if (n == 1) z = vecs[2].z;
            if (n == 3) start = 1'b1;
            if (n == 4) start = 1'b0;
        end
        start = 1'b0;
        check("busy_start_done_count", 32'(dcount), 32'd1);
        check("busy_start_latency", 32'(dn), 32'd7);
        check_y("busy_start", vecs[0]);
        check("done_start_ignored", {31'b0, busy_late}, 32'd0);

        // Asynchronous reset during the second MUL state.
        set_cfg(vecs[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int n = 1; n <= 3; n++) begin
            @(posedge clk); #1;
        end
        #2 reset = 1'b0;
        #1;
        check("midrst_y_nonzero", {31'b0, |y}, 32'd0);
        check("midrst_busy_done", {30'b0, done, busy}, 32'd0);
        @(negedge clk);
        reset  = 1'b1;
        dcount = 0;
        bb     = 1'b0;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk); #1;
            if (done) dcount++;
            if (busy) bb = 1'b1;
        end
        check("midrst_no_done", 32'(dcount), 32'd0);
        check("midrst_stays_idle", 32'(bb), 32'd0);
        run_txn(lat, bb);
        check("midrst_fresh_latency", 32'(lat), 32'd7);
        check_y("midrst_fresh", vecs[1]);
        @(posedge clk); #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
